// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: definitions shared by the serial arithmetic blocks.
//   state_e   - controller state (IDLE, RUN, DONE), 2-bit encoding
//   MODE_ADD  - sub input value selecting a+b
//   MODE_SUB  - sub input value selecting a-b
//   maj3()    - full-adder carry (majority of three)
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/result handshake bundle for serial_addsub.
//   master: drives start, sub, shift, a, b; observes sum, cout, busy, done (and ovf)
//   slave : the arithmetic unit
// Optional: SERIAL_ADDSUB_OVF_EN adds the ovf (signed overflow) signal.
interface serial_addsub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic             shift;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, sub, shift, a, b,
    input  sum, cout, busy, done
`ifdef SERIAL_ADDSUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, sub, shift, a, b,
    output sum, cout, busy, done
`ifdef SERIAL_ADDSUB_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_bit_cell.sv
// serial_bit_cell: one-bit full adder with its carry flop.
//   clk, reset  - clock, synchronous active-high reset
//   load_i      - load carry with load_val_i (has priority over en_i)
//   en_i        - latch the adder carry-out into the carry flop
//   a_i, b_i    - operand bits
//   s_o         - sum bit of a_i + b_i + carry
//   c_o         - current carry flop value
module serial_bit_cell
  import serial_arith_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic load_val_i,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  logic carry_q;

  assign s_o = a_i ^ b_i ^ carry_q;
  assign c_o = carry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (load_i) begin
      carry_q <= load_val_i;
    end else if (en_i) begin
      carry_q <= maj3(a_i, b_i, carry_q);
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: WIDTH-bit bit-serial adder/subtractor, LSB first.
//   clk, reset - clock, synchronous active-high reset
//   bus        - serial_addsub_if.slave: start/sub/shift/a/b in,
//                sum/cout/busy/done (and ovf) out
// Outputs are registered: done pulses one cycle after the DONE state,
// busy covers the cycle after an accepted start through the done cycle.
// Optional: SERIAL_ADDSUB_OVF_EN adds signed-overflow reporting on bus.ovf.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | one bit per shift=1 edge, LSB first
// DONE  | publish result register and carry
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             reset,
  serial_addsub_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load, load_val, en;
  logic               s_bit, carry;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic               ovf_r_q, ovf_r_d;
  logic               ovf_q, ovf_d;
`endif

  serial_bit_cell u_cell (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (load_val),
    .en_i       (en),
    .a_i        (a_sr_q[0]),
    .b_i        (b_sr_q[0]),
    .s_o        (s_bit),
    .c_o        (carry)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    load     = 1'b0;
    load_val = 1'b0;
    en       = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_r_d  = ovf_r_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d   = bus.a;
          // Subtraction as a + ~b + 1: invert b here, carry-in of 1 below.
          b_sr_d   = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
          load     = 1'b1;
          load_val = bus.sub;
          cnt_d    = '0;
          res_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.shift) begin
          en     = 1'b1;
          a_sr_d = a_sr_q >> 1;
          b_sr_d = b_sr_q >> 1;
          res_d  = {s_bit, res_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
            // Carry into the MSB is the flop; carry out is what it is about to load.
            ovf_r_d = carry ^ maj3(a_sr_q[0], b_sr_q[0], carry);
`endif
          end
        end
      end
      DONE: begin
        sum_d   = res_q;
        cout_d  = carry;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d   = ovf_r_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_q == DONE);
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_r_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_r_q <= ovf_r_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor. It is the next generation of the 4-bit serial adder datapath (PISO operands, full adder, carry flop, SIPO result).
- Generalised to WIDTH bits.
- Adds an add/sub mode, a start/busy/done handshake and a shift-stall input.
- Reports carry-out/not-borrow.
- Sits beside the existing serial arithmetic blocks as a low-area arithmetic unit for control paths.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request: capture operands and begin; honoured only in IDLE
sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b
shift  input  1  advance enable during RUN; 0 stalls all datapath and counter state
a  input  WIDTH  operand A, sampled on the start edge
b  input  WIDTH  operand B, sampled on the start edge
sum  output  WIDTH  result; valid from done and held until the next accepted start
cout  output  1  final carry; in sub mode 1 = no borrow (a >= b unsigned)
busy  output  1  high while in RUN or DONE
done  output  1  single-cycle pulse when sum/cout become valid

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - State -> IDLE.
  - sum, cout, busy, done, internal shift registers, carry flop and bit counter all -> 0.
- State IDLE:
  - busy=0, done=0.
  - start=1 at a rising edge causes:
    - a_sr <= a.
    - b_sr <= sub ? ~b : b.
    - carry <= sub.
    - cnt <= 0.
    - result register <= 0.
    - state -> RUN.
- State RUN:
  - busy=1.
  - On each edge with shift=1:
    - s = a_sr[0] ^ b_sr[0] ^ carry.
    - carry <= majority(a_sr[0], b_sr[0], carry).
    - a_sr and b_sr shift right, with 0 filled into the MSB.
    - The result register shifts right with s entering at the MSB.
    - cnt <= cnt+1.
  - The edge that processes bit WIDTH-1 moves state -> DONE.
  - With shift=0, nothing changes.
- State DONE, one cycle:
  - done=1, busy=1.
  - sum = result register; cout = carry.
  - Next edge -> IDLE unconditionally.
- Latency: with shift held high, done is high in the cycle after edge WIDTH+1, counting the start-sampling edge as edge 0. Each shift=0 cycle in RUN adds exactly one cycle.
- start while busy is ignored: no operand capture, no restart.
- shift is ignored outside RUN.
- sum/cout stay stable through IDLE until the next accepted start. On that start edge they are not cleared; they change only when the next DONE is reached.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement: a + ~b + 1.
- Reset asserted mid-RUN aborts the operation: no done pulse, and outputs go to 0 as above.
- cnt is $clog2(WIDTH) bits wide. The DONE transition is decoded at cnt == WIDTH-1, so there is no wrap for non-power-of-2 WIDTH.

Optional Feature:
Macro SERIAL_ADDSUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow of the operation.
  - Computed as the carry into the MSB XOR the carry out of the MSB, captured on the edge processing bit WIDTH-1.
  - Valid with done, held like sum, and reset to 0.
- Undefined:
  - No ovf port and no extra flop.
  - All other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - the state typedef (IDLE, RUN, DONE; 2-bit encoding);
  - the mode constants MODE_ADD=0 and MODE_SUB=1.
- One natural sub-module, serial_bit_cell: full adder plus the carry flop with synchronous load and an enable.
- The shift registers, counter and FSM stay in serial_addsub.

Test Plan:
1. WIDTH=4, sub=0, a=4'h3, b=4'h5, shift=1 -> done pulse in the cycle after edge 5, sum=4'h8, cout=0, busy low the cycle after done.
2. WIDTH=4, add 4'hF+4'h1 -> sum=4'h0, cout=1. Then sub 4'h7-4'h9 -> sum=4'hE, cout=0. Then sub 4'h9-4'h7 -> sum=4'h2, cout=1.
3. Stall and start-while-busy (WIDTH=4, a=4'h3, b=4'h5, sub=0):
   - start accepted; shift=0 for 3 cycles mid-RUN -> done delayed by exactly 3 cycles, sum unchanged (4'h8).
   - start pulsed while busy with a=4'hA -> ignored, result still 4'h8.
4. Reset for one cycle at the second RUN edge -> busy=0, sum=0, cout=0, no done pulse. A new start afterwards computes correctly.
5. WIDTH=8, sub=1, a=8'h00, b=8'h01 -> sum=8'hFF, cout=0, done in the cycle after edge 9. WIDTH=5 (non-power-of-2), 5'h1F+5'h01 -> sum=0, cout=1.
6. With SERIAL_ADDSUB_OVF_EN, WIDTH=4:
   - 4'h7+4'h1 -> ovf=1.
   - 4'h8-4'h1 -> ovf=1.
   - 4'h3+4'h2 -> ovf=0.
   - Without the macro, the design elaborates with no ovf port.
